gpio_atr_sched: RTL
===================

Name: gpio_atr_sched

Overview:
- Automatic transmit/receive (ATR) scheduler that drives the tx/rx select inputs of the GPIO ATR block, i.e. chooses which of its idle/rx/tx/fdx pin patterns is applied.
- Sequences radio front-end switching from DSP run_tx/run_rx requests.
- Adds a programmable transmit lead time (PA/switch settle before samples flow) and tail time (hold after the burst), with an optional full-duplex mode and a software force override.
- Sits between the DSP core control signals and the GPIO ATR block. It is configured over the settings bus.

Parameters:
- BASE, 0, settings-bus base address; occupies BASE+0..BASE+2.
- CNT_W, 16, width of the lead and tail counters.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- set_stb  input  1  settings write strobe
- set_addr  input  8  settings address
- set_data  input  32  settings data
- run_tx  input  1  DSP transmit request (level)
- run_rx  input  1  DSP receive request (level)
- atr_tx  output  1  tx select to the GPIO ATR block
- atr_rx  output  1  rx select to the GPIO ATR block
- tx_ready  output  1  transmit path may stream samples
- sched_state  output  3  current FSM state, for readback

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low (reset_n).
- Settings registers. Each is written on the cycle where set_stb=1 and set_addr matches. All reset to 0.
  - BASE+0 = lead[CNT_W-1:0].
  - BASE+1 = tail[CNT_W-1:0].
  - BASE+2 = ctrl, with bit0 fdx_en, bit1 force_en, bit2 force_rx, bit3 force_tx.
- Counter loading: lead and tail are sampled only on entry to TX_LEAD or TX_TAIL. A write made mid-count takes effect on the next entry.
- All outputs are registered. Reset values: atr_tx=0, atr_rx=0, tx_ready=0, sched_state=IDLE.
- State encodings: IDLE=0, RX=1, TX_LEAD=2, TX=3, TX_TAIL=4.
- IDLE:
  - run_tx=1 -> TX_LEAD with cnt=lead-1; if lead=0, go to TX instead.
  - else run_rx=1 -> RX.
- RX:
  - run_tx=1 -> TX_LEAD or TX, same rule as IDLE (tx has priority).
  - else run_rx=0 -> IDLE.
- TX_LEAD:
  - cnt decrements each cycle; at cnt=0 -> TX.
  - run_tx=0 (abort) -> TX_TAIL with cnt=tail-1; if tail=0, go to the tail exit target.
- TX:
  - run_tx=0 -> TX_TAIL with cnt=tail-1; if tail=0, go to the tail exit target.
- TX_TAIL:
  - run_tx=1 -> TX directly; no new lead time, the PA is still warm.
  - else at cnt=0, exit: RX if run_rx=1, else IDLE.
- Output decode:
  - atr_tx=1 in TX_LEAD, TX and TX_TAIL.
  - tx_ready=1 only in TX.
  - atr_rx=1 in RX. In the tx states atr_rx=fdx_en & run_rx; this selects the fdx pattern.
  - Latency: atr_tx rises 1 cycle after run_tx is sampled. tx_ready rises exactly lead cycles after atr_tx.
- Force mode (force_en=1):
  - FSM is held in IDLE and tx_ready=0.
  - atr_tx=force_tx and atr_rx=force_rx, taking effect on the next cycle.
  - On clearing force_en, the FSM resumes from IDLE.
- Reset asserted mid-burst: immediate return to reset values; atr_tx drops asynchronously.
- Arithmetic: counters are unsigned CNT_W-bit. They never wrap because zero is handled by skipping the state.

Optional Feature:
- Macro: GPIO_ATR_SCHED_STATS_EN.
- When defined, adds:
  - output burst_count[31:0], incremented on each TX_LEAD/TX entry from IDLE or RX;
  - output abort_count[15:0], incremented on each TX_LEAD->TX_TAIL abort.
- Both counters wrap at their maximum, reset to 0, and are cleared by writing any value to BASE+3.
- When undefined, these ports and the BASE+3 decode do not exist.

Decomposition:
- Shared package gpio_atr_pkg holds:
  - state encoding constants (IDLE..TX_TAIL);
  - register offsets (OFF_LEAD=0, OFF_TAIL=1, OFF_CTRL=2, OFF_STATS_CLR=3);
  - ctrl bit indices.
- The settings registers reuse the existing setting_reg.
- One natural sub-module: gpio_atr_sched_cnt, a loadable down-counter with a zero flag, used for both lead and tail.

Test Plan:
- lead=5, tail=3, run_tx pulsed high for 20 cycles from IDLE:
  - atr_tx rises at cycle 1;
  - tx_ready rises at cycle 6 and falls when run_tx falls;
  - atr_tx falls 3 cycles after TX_TAIL entry.
- lead=0, tail=0: run_tx rise -> tx_ready rises in the same cycle as atr_tx; run_tx fall -> both drop the next cycle.
- run_rx=1 and fdx_en=1, then run_tx burst:
  - atr_rx stays 1 throughout;
  - with fdx_en=0, atr_rx=0 in TX_LEAD..TX_TAIL and returns to 1 after the tail.
- lead=10, run_tx dropped at lead cycle 4 -> abort into TX_TAIL, tx_ready never asserts; abort_count=1 when the stats macro is enabled.
- tail=8, run_tx reasserted at tail cycle 3 -> straight to TX, tx_ready next cycle, no lead.
- ctrl=0xA (force_en, force_tx) during RX -> atr_tx=1, atr_rx=0, sched_state=0; reset_n low mid-TX -> all outputs 0 immediately.

Source files
------------

// File: rtl/gpio_atr_pkg.sv
// gpio_atr_pkg: shared state encodings, settings offsets and ctrl bit positions for the ATR scheduler
package gpio_atr_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX      = 3'd1,
    TX_LEAD = 3'd2,
    TX      = 3'd3,
    TX_TAIL = 3'd4
  } state_t;
  localparam logic [7:0] OFF_LEAD = 8'd0;
  localparam logic [7:0] OFF_TAIL = 8'd1;
  localparam logic [7:0] OFF_CTRL = 8'd2;
  localparam logic [7:0] OFF_STATS_CLR = 8'd3;
  localparam int CTRL_FDX_EN = 0;
  localparam int CTRL_FORCE_EN = 1;
  localparam int CTRL_FORCE_RX = 2;
  localparam int CTRL_FORCE_TX = 3;
endpackage

// File: rtl/gpio_atr_sched_cnt.sv
// gpio_atr_sched_cnt: loadable down-counter with zero flag, shared by the lead and tail phases
module gpio_atr_sched_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  localparam logic [W-1:0] ONE = 1;
  logic [W-1:0] cnt;
  // load has priority; decrement only when asked so the value parks at zero
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - ONE;
  assign zero = cnt == '0;
endmodule

// File: rtl/setting_reg.sv
// setting_reg: one settings-bus register captured when the strobe hits its address
module setting_reg #(
  parameter int AWIDTH = 8,
  parameter logic [AWIDTH-1:0] MY_ADDR = '0,
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              strobe,
  input  logic [AWIDTH-1:0] addr,
  input  logic [WIDTH-1:0]  in,
  output logic [WIDTH-1:0]  out
);
  // capture the bus data on a matching write
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) out <= '0;
    else if (strobe && addr == MY_ADDR) out <= in;
endmodule

// File: rtl/gpio_atr_sched.sv
// gpio_atr_sched: ATR scheduler with tx lead/tail timing, fdx and force override; GPIO_ATR_SCHED_STATS_EN adds burst/abort counters
module gpio_atr_sched
  import gpio_atr_pkg::*;
#(
  parameter logic [7:0] BASE = 8'd0,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        run_tx,
  input  logic        run_rx,
  output logic        atr_tx,
  output logic        atr_rx,
  output logic        tx_ready,
  output logic [2:0]  sched_state
`ifdef GPIO_ATR_SCHED_STATS_EN
  ,
  output logic [31:0] burst_count,
  output logic [15:0] abort_count
`endif
);
  localparam logic [CNT_W-1:0] ONE = 1;
  logic [CNT_W-1:0] lead, tail, ld_val;
  logic [3:0] ctrl;
  logic fdx_en, force_en, force_rx, force_tx;
  logic cnt_zero, load, ld_tail, dec, nxt_tx;
  logic unused_data;
  state_t st, nxt, tail_exit, tail_go;
  setting_reg #(.AWIDTH(8), .MY_ADDR(BASE + OFF_LEAD), .WIDTH(CNT_W)) u_lead (
    .clk(clk), .reset_n(reset_n), .strobe(set_stb), .addr(set_addr),
    .in(set_data[CNT_W-1:0]), .out(lead)
  );
  setting_reg #(.AWIDTH(8), .MY_ADDR(BASE + OFF_TAIL), .WIDTH(CNT_W)) u_tail (
    .clk(clk), .reset_n(reset_n), .strobe(set_stb), .addr(set_addr),
    .in(set_data[CNT_W-1:0]), .out(tail)
  );
  setting_reg #(.AWIDTH(8), .MY_ADDR(BASE + OFF_CTRL), .WIDTH(4)) u_ctrl (
    .clk(clk), .reset_n(reset_n), .strobe(set_stb), .addr(set_addr),
    .in(set_data[3:0]), .out(ctrl)
  );
  assign unused_data = ^set_data[31:4];
  assign fdx_en = ctrl[CTRL_FDX_EN];
  assign force_en = ctrl[CTRL_FORCE_EN];
  assign force_rx = ctrl[CTRL_FORCE_RX];
  assign force_tx = ctrl[CTRL_FORCE_TX];
  assign tail_exit = run_rx ? RX : IDLE;
  assign tail_go = tail == '0 ? tail_exit : TX_TAIL;
  assign ld_val = ld_tail ? tail - ONE : lead - ONE;
  gpio_atr_sched_cnt #(.W(CNT_W)) u_cnt (
    .clk(clk), .reset_n(reset_n), .load(load), .load_val(ld_val),
    .dec(dec), .zero(cnt_zero)
  );
  // next state and counter control; zero lead/tail skips the timed state so the counter never wraps
  always_comb begin
    nxt = st;
    load = 1'b0;
    ld_tail = 1'b0;
    dec = 1'b0;
    case (st)
      IDLE, RX: begin
        nxt = run_tx ? (lead == '0 ? TX : TX_LEAD) : (run_rx ? RX : IDLE);
        load = run_tx;
      end
      TX_LEAD: begin
        nxt = !run_tx ? tail_go : (cnt_zero ? TX : TX_LEAD);
        load = !run_tx;
        ld_tail = !run_tx;
        dec = run_tx && !cnt_zero;
      end
      TX: begin
        nxt = run_tx ? TX : tail_go;
        load = !run_tx;
        ld_tail = !run_tx;
      end
      TX_TAIL: begin
        nxt = run_tx ? TX : (cnt_zero ? tail_exit : TX_TAIL);
        dec = !run_tx && !cnt_zero;
      end
      default: nxt = IDLE;
    endcase
    if (force_en) begin
      nxt = IDLE;
      load = 1'b0;
      dec = 1'b0;
    end
  end
  assign nxt_tx = nxt inside {TX_LEAD, TX, TX_TAIL};
  // state register and outputs decoded from the next state so every output is registered
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st <= IDLE;
      atr_tx <= 1'b0;
      atr_rx <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      st <= nxt;
      atr_tx <= force_en ? force_tx : nxt_tx;
      atr_rx <= force_en ? force_rx : (nxt == RX) || (nxt_tx && fdx_en && run_rx);
      tx_ready <= !force_en && nxt == TX;
    end
  assign sched_state = st;
`ifdef GPIO_ATR_SCHED_STATS_EN
  logic stats_clr;
  assign stats_clr = set_stb && set_addr == BASE + OFF_STATS_CLR;
  // burst starts from IDLE/RX and lead aborts; a clear write wins over a same-cycle increment
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      burst_count <= '0;
      abort_count <= '0;
    end else if (stats_clr) begin
      burst_count <= '0;
      abort_count <= '0;
    end else begin
      if (!force_en && run_tx && (st == IDLE || st == RX)) burst_count <= burst_count + 32'd1;
      if (!force_en && !run_tx && st == TX_LEAD) abort_count <= abort_count + 16'd1;
    end
`endif
endmodule
